// File: rtl/usxgmii_rate_adapt_scheduler.sv
// usxgmii_rate_adapt_scheduler
// Pulls 32-bit USXGMII words from the upstream clock-crossing stage and
// replicates each one 1/2/4/10/100/1000 times according to the negotiated
// link speed. The result is a continuous word stream for the PCS.
// When no word is available, idle is substituted. An underrun inside a
// frame produces a single error word, and the rest of that frame is dropped.
// Optional statistics counters are enabled by defining USXGMII_SCHED_STATS_EN.
module usxgmii_rate_adapt_scheduler #(
    parameter int p_STAT_WIDTH = 16
) (
    input  logic                    i_usxgmii_clock,
    input  logic                    i_usxgmii_reset,
    input  logic [2:0]              i_speed,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [3:0]              i_control,
    input  logic [31:0]             i_data,
    output logic                    o_usxgmii_valid,
    output logic                    o_usxgmii_first,
    output logic [3:0]              o_usxgmii_control,
    output logic [31:0]             o_usxgmii_data,
    output logic [p_STAT_WIDTH-1:0] o_frame_count,
    output logic [p_STAT_WIDTH-1:0] o_underrun_count
);

    localparam logic [3:0]  IDLE_CONTROL = 4'hF;
    localparam logic [31:0] IDLE_DATA    = 32'h07070707;
    localparam logic [31:0] ERROR_DATA   = 32'hFEFEFEFE;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        ABORT
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [9:0]  rep_cnt;
    logic [9:0]  n_factor;
    logic [9:0]  speed_factor;
    logic        speed_ok;
    logic        boundary;
    logic        accept;
    logic        is_start;
    logic        is_term;
    logic [3:0]  next_control;
    logic [31:0] next_data;

    assign boundary = (rep_cnt == n_factor - 10'd1);
    assign o_ready  = boundary;
    assign accept   = i_valid & boundary;
    assign is_start = i_control[0] & (i_data[7:0] == 8'hFB);

    // A terminate character may appear in any lane
    always_comb begin
        is_term = 1'b0;
        for (int lane = 0; lane < 4; lane++) begin
            if (i_control[lane] && (i_data[8*lane +: 8] == 8'hFD)) begin
                is_term = 1'b1;
            end
        end
    end

    // Translate the speed code into a replication factor; reserved codes keep the current one
    always_comb begin
        speed_ok     = 1'b1;
        speed_factor = n_factor;
        case (i_speed)
            3'd0:    speed_factor = 10'd1;
            3'd1:    speed_factor = 10'd2;
            3'd2:    speed_factor = 10'd4;
            3'd3:    speed_factor = 10'd10;
            3'd4:    speed_factor = 10'd100;
            3'd5:    speed_factor = 10'd1000;
            default: speed_ok     = 1'b0;
        endcase
    end

    // Choose the word to load at the next boundary and the frame state that follows it
    always_comb begin
        next_state   = state;
        next_control = IDLE_CONTROL;
        next_data    = IDLE_DATA;
        if (accept) begin
            if (state != ABORT || is_start) begin
                next_control = i_control;
                next_data    = i_data;
            end
            if (is_term) begin
                next_state = IDLE;
            end else if (is_start && state != FRAME) begin
                next_state = FRAME;
            end
        end else if (state == FRAME) begin
            next_control = IDLE_CONTROL;
            next_data    = ERROR_DATA;
            next_state   = ABORT;
        end
    end

    // Replica counting, word loading and speed latching; outputs change only at word boundaries
    always_ff @(posedge i_usxgmii_clock) begin
        if (i_usxgmii_reset) begin
            state             <= IDLE;
            rep_cnt           <= 10'd0;
            n_factor          <= 10'd1;
            o_usxgmii_valid   <= 1'b0;
            o_usxgmii_first   <= 1'b0;
            o_usxgmii_control <= IDLE_CONTROL;
            o_usxgmii_data    <= IDLE_DATA;
        end else begin
            o_usxgmii_valid <= 1'b1;
            if (boundary) begin
                rep_cnt           <= 10'd0;
                state             <= next_state;
                o_usxgmii_first   <= 1'b1;
                o_usxgmii_control <= next_control;
                o_usxgmii_data    <= next_data;
                if (next_state == IDLE && speed_ok) begin
                    n_factor <= speed_factor;
                end
            end else begin
                rep_cnt         <= rep_cnt + 10'd1;
                o_usxgmii_first <= 1'b0;
            end
        end
    end

`ifdef USXGMII_SCHED_STATS_EN
    logic                    count_frame;
    logic                    count_underrun;
    logic [p_STAT_WIDTH-1:0] frame_count;
    logic [p_STAT_WIDTH-1:0] underrun_count;

    // A start seen outside a frame opens a new frame; a missing word inside a frame is an underrun
    always_comb begin
        count_frame    = accept & is_start & (state != FRAME);
        count_underrun = boundary & ~i_valid & (state == FRAME);
    end

    // Saturating statistics counters
    always_ff @(posedge i_usxgmii_clock) begin
        if (i_usxgmii_reset) begin
            frame_count    <= '0;
            underrun_count <= '0;
        end else begin
            if (count_frame && !(&frame_count)) begin
                frame_count <= frame_count + 1'b1;
            end
            if (count_underrun && !(&underrun_count)) begin
                underrun_count <= underrun_count + 1'b1;
            end
        end
    end

    assign o_frame_count    = frame_count;
    assign o_underrun_count = underrun_count;
`else
    assign o_frame_count    = '0;
    assign o_underrun_count = '0;
`endif

endmodule

// File: tb/tb_usxgmii_rate_adapt_scheduler.sv
// Testbench for usxgmii_rate_adapt_scheduler.
// The reference model predicts the output stream one word at a time. For
// every word accepted or substituted, it appends N replicas to a queue of
// expected output cycles.
module tb_usxgmii_rate_adapt_scheduler;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    speed;
    logic          iv;
    logic          ready;
    logic [3:0]    ic;
    logic [31:0]   id;
    logic          ov;
    logic          of;
    logic [3:0]    oc;
    logic [31:0]   od;
    logic [W-1:0]  fc;
    logic [W-1:0]  uc;

    typedef struct packed {
        logic        v;
        logic        f;
        logic [3:0]  c;
        logic [31:0] d;
    } out_t;

    typedef struct packed {
        logic [3:0]  c;
        logic [31:0] d;
    } word_t;

    localparam out_t RESET_WORD = {1'b0, 1'b0, 4'hF, 32'h07070707};

    out_t  exp_q[$];
    word_t src_q[$];
    int    m_mode;      // 0 = between frames, 1 = inside frame, 2 = discarding aborted frame
    int    m_n;
    int    m_frames;
    int    m_underruns;
    int    n_checks;
    int    n_fail;
    int    cyc;

    always #5 clk = ~clk;

    usxgmii_rate_adapt_scheduler #(.p_STAT_WIDTH(W)) dut (
        .i_usxgmii_clock   (clk),
        .i_usxgmii_reset   (rst),
        .i_speed           (speed),
        .i_valid           (iv),
        .o_ready           (ready),
        .i_control         (ic),
        .i_data            (id),
        .o_usxgmii_valid   (ov),
        .o_usxgmii_first   (of),
        .o_usxgmii_control (oc),
        .o_usxgmii_data    (od),
        .o_frame_count     (fc),
        .o_underrun_count  (uc)
    );

    function automatic int factor_of(input logic [2:0] code);
        case (code)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 4;
            3'd3:    return 10;
            3'd4:    return 100;
            3'd5:    return 1000;
            default: return 0;
        endcase
    endfunction

    function automatic word_t random_word();
        word_t w;
        int    kind;
        int    lane;
        kind = $urandom_range(0, 9);
        w.d  = $urandom;
        w.c  = 4'h0;
        if (kind <= 1) begin
            w.c      = 4'h1;
            w.d[7:0] = 8'hFB;
        end else if (kind == 2) begin
            lane                = $urandom_range(0, 3);
            w.c[lane]           = 1'b1;
            w.d[8*lane +: 8]    = 8'hFD;
        end else if (kind == 3) begin
            w.c        = 4'b1001;
            w.d[7:0]   = 8'hFB;
            w.d[31:24] = 8'hFD;
        end
        return w;
    endfunction

    // Offer the head of the source queue (or junk with valid low), then move to the sampling point
    task automatic drive(input bit gate);
        iv = gate && (src_q.size() > 0);
        if (iv) begin
            ic = src_q[0].c;
            id = src_q[0].d;
        end else begin
            ic = 4'($urandom);
            id = $urandom;
        end
        @(negedge clk);
    endtask

    // Advance the reference model across the coming clock edge
    task automatic tick();
        bit    boundary;
        bit    s;
        bit    t;
        out_t  w;
        int    f;
        if (rst) begin
            exp_q.delete();
            exp_q.push_back(RESET_WORD);
            m_n         = 1;
            m_mode      = 0;
            m_frames    = 0;
            m_underruns = 0;
        end else begin
            boundary = (exp_q.size() <= 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (boundary) begin
                w = {1'b1, 1'b1, 4'hF, 32'h07070707};
                if (iv) begin
                    s = ic[0] && (id[7:0] == 8'hFB);
                    t = 1'b0;
                    for (int l = 0; l < 4; l++) begin
                        if (ic[l] && id[8*l +: 8] == 8'hFD) t = 1'b1;
                    end
                    if (m_mode == 2 && !s) begin
                        if (t) m_mode = 0;
                    end else begin
                        w.c = ic;
                        w.d = id;
                        if (s && m_mode != 1 && m_frames < (1 << W) - 1) m_frames++;
                        if (t) m_mode = 0;
                        else if (s) m_mode = 1;
                    end
                    void'(src_q.pop_front());
                end else if (m_mode == 1) begin
                    w.d = 32'hFEFEFEFE;
                    if (m_underruns < (1 << W) - 1) m_underruns++;
                    m_mode = 2;
                end
                f = factor_of(speed);
                if (m_mode == 0 && f > 0) m_n = f;
                for (int k = 0; k < m_n; k++) begin
                    w.f = (k == 0);
                    exp_q.push_back(w);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        out_t obs;
        rst   = 1'b1;
        speed = 3'd0;
        iv    = 1'b0;
        ic    = 4'h0;
        id    = 32'h0;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0);
            obs = {ov, of, oc, od};
            n_checks++;
            if (obs !== RESET_WORD) begin
                n_fail++;
                $display("[TB] FAIL reset_value cycle %0d: got %h expected %h", cyc, obs, RESET_WORD);
            end
            n_checks++;
            if (ready !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL reset_ready cycle %0d: got %b expected 1", cyc, ready);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_stream();
        out_t obs;
        speed = 3'd0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0);
            obs = {ov, of, oc, od};
            n_checks++;
            if (obs !== exp_q[0]) begin
                n_fail++;
                $display("[TB] FAIL idle_word cycle %0d: got %h expected %h", cyc, obs, exp_q[0]);
            end
            n_checks++;
            if (ready !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL idle_ready cycle %0d: got %b expected 1", cyc, ready);
            end
            tick();
        end
    endtask

    task automatic test_frame_x1();
        out_t          obs;
        logic [W-1:0]  exp_fc;
        speed = 3'd0;
        src_q.push_back({4'h1, 32'h554433FB});
        src_q.push_back({4'h0, 32'hA1A2A3A4});
        src_q.push_back({4'h0, 32'hB1B2B3B4});
        src_q.push_back({4'h8, 32'hFD0C0B0A});
        for (int i = 0; i < 8; i++) begin
            drive(1'b1);
            obs = {ov, of, oc, od};
            n_checks++;
            if (obs !== exp_q[0]) begin
                n_fail++;
                $display("[TB] FAIL frame_x1_word cycle %0d: got %h expected %h", cyc, obs, exp_q[0]);
            end
            n_checks++;
            if (ready !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL frame_x1_ready cycle %0d: got %b expected 1", cyc, ready);
            end
            tick();
        end
`ifdef USXGMII_SCHED_STATS_EN
        exp_fc = W'(m_frames);
`else
        exp_fc = '0;
`endif
        n_checks++;
        if (fc !== exp_fc) begin
            n_fail++;
            $display("[TB] FAIL frame_x1_count: got %0d expected %0d", fc, exp_fc);
        end
    endtask

    task automatic test_replication_x10();
        out_t obs;
        int   held;
        int   firsts;
        speed  = 3'd3;
        held   = 0;
        firsts = 0;
        src_q.push_back({4'h0, 32'h11223344});
        for (int i = 0; i < 35; i++) begin
            drive(1'b1);
            obs = {ov, of, oc, od};
            if (od === 32'h11223344) begin
                held++;
                if (of === 1'b1) firsts++;
            end
            n_checks++;
            if (obs !== exp_q[0]) begin
                n_fail++;
                $display("[TB] FAIL x10_word cycle %0d: got %h expected %h", cyc, obs, exp_q[0]);
            end
            n_checks++;
            if (ready !== (exp_q.size() <= 1)) begin
                n_fail++;
                $display("[TB] FAIL x10_ready cycle %0d: got %b expected %b", cyc, ready, exp_q.size() <= 1);
            end
            tick();
        end
        n_checks++;
        if (held != 10) begin
            n_fail++;
            $display("[TB] FAIL x10_hold_length: got %0d expected 10", held);
        end
        n_checks++;
        if (firsts != 1) begin
            n_fail++;
            $display("[TB] FAIL x10_first_count: got %0d expected 1", firsts);
        end
    endtask

    task automatic test_underrun();
        out_t          obs;
        logic [W-1:0]  exp_uc;
        logic [W-1:0]  exp_fc;
        int            errors;
        speed  = 3'd0;
        errors = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0);
            tick();
        end
        src_q.push_back({4'h1, 32'h000000FB});
        src_q.push_back({4'h0, 32'h01010101});
        src_q.push_back({4'h0, 32'h02020202});
        src_q.push_back({4'h0, 32'h03030303});
        src_q.push_back({4'h4, 32'h00FD0000});
        src_q.push_back({4'h1, 32'h123456FB});
        src_q.push_back({4'h0, 32'h04040404});
        src_q.push_back({4'h2, 32'h0000FD00});
        for (int i = 0; i < 14; i++) begin
            drive(i != 2);
            obs = {ov, of, oc, od};
            if (od === 32'hFEFEFEFE) errors++;
            n_checks++;
            if (obs !== exp_q[0]) begin
                n_fail++;
                $display("[TB] FAIL underrun_word cycle %0d: got %h expected %h", cyc, obs, exp_q[0]);
            end
            n_checks++;
            if (ready !== (exp_q.size() <= 1)) begin
                n_fail++;
                $display("[TB] FAIL underrun_ready cycle %0d: got %b expected %b", cyc, ready, exp_q.size() <= 1);
            end
            tick();
        end
        n_checks++;
        if (errors != 1) begin
            n_fail++;
            $display("[TB] FAIL underrun_error_words: got %0d expected 1", errors);
        end
`ifdef USXGMII_SCHED_STATS_EN
        exp_uc = W'(m_underruns);
        exp_fc = W'(m_frames);
`else
        exp_uc = '0;
        exp_fc = '0;
`endif
        n_checks++;
        if (uc !== exp_uc) begin
            n_fail++;
            $display("[TB] FAIL underrun_count: got %0d expected %0d", uc, exp_uc);
        end
        n_checks++;
        if (fc !== exp_fc) begin
            n_fail++;
            $display("[TB] FAIL underrun_frame_count: got %0d expected %0d", fc, exp_fc);
        end
    endtask

    task automatic test_speed_change();
        out_t obs;
        speed = 3'd0;
        src_q.push_back({4'h1, 32'hAABBCCFB});
        src_q.push_back({4'h0, 32'h10203040});
        src_q.push_back({4'h0, 32'h50607080});
        src_q.push_back({4'h0, 32'h90A0B0C0});
        src_q.push_back({4'h1, 32'h000000FD});
        for (int i = 0; i < 20; i++) begin
            if (i == 2) speed = 3'd2;
            drive(1'b1);
            obs = {ov, of, oc, od};
            n_checks++;
            if (obs !== exp_q[0]) begin
                n_fail++;
                $display("[TB] FAIL speed_change_word cycle %0d: got %h expected %h", cyc, obs, exp_q[0]);
            end
            n_checks++;
            if (ready !== (exp_q.size() <= 1)) begin
                n_fail++;
                $display("[TB] FAIL speed_change_ready cycle %0d: got %b expected %b", cyc, ready, exp_q.size() <= 1);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        out_t obs;
        speed = 3'd5;
        src_q.delete();
        for (int i = 0; i < 30; i++) begin
            drive(1'b0);
            tick();
        end
        rst = 1'b1;
        drive(1'b0);
        tick();
        rst   = 1'b0;
        speed = 3'd0;
        src_q.push_back({4'h0, 32'hCAFEF00D});
        for (int i = 0; i < 6; i++) begin
            drive(1'b1);
            obs = {ov, of, oc, od};
            if (i == 0) begin
                n_checks++;
                if (obs !== RESET_WORD) begin
                    n_fail++;
                    $display("[TB] FAIL reset_mid_value cycle %0d: got %h expected %h", cyc, obs, RESET_WORD);
                end
            end
            n_checks++;
            if (obs !== exp_q[0]) begin
                n_fail++;
                $display("[TB] FAIL reset_mid_word cycle %0d: got %h expected %h", cyc, obs, exp_q[0]);
            end
            n_checks++;
            if (ready !== (exp_q.size() <= 1)) begin
                n_fail++;
                $display("[TB] FAIL reset_mid_ready cycle %0d: got %b expected %b", cyc, ready, exp_q.size() <= 1);
            end
            tick();
        end
    endtask

    task automatic test_random();
        out_t          obs;
        logic [W-1:0]  exp_fc;
        logic [W-1:0]  exp_uc;
        logic [2:0]    speeds[7];
        speeds = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) speed = speeds[$urandom_range(0, 6)];
            while (src_q.size() < 4) src_q.push_back(random_word());
            drive($urandom_range(0, 3) != 0);
            obs = {ov, of, oc, od};
            n_checks++;
            if (obs !== exp_q[0]) begin
                n_fail++;
                $display("[TB] FAIL random_word cycle %0d: got %h expected %h", cyc, obs, exp_q[0]);
            end
            n_checks++;
            if (ready !== (exp_q.size() <= 1)) begin
                n_fail++;
                $display("[TB] FAIL random_ready cycle %0d: got %b expected %b", cyc, ready, exp_q.size() <= 1);
            end
            tick();
        end
`ifdef USXGMII_SCHED_STATS_EN
        exp_fc = W'(m_frames);
        exp_uc = W'(m_underruns);
`else
        exp_fc = '0;
        exp_uc = '0;
`endif
        n_checks++;
        if (fc !== exp_fc) begin
            n_fail++;
            $display("[TB] FAIL random_frame_count: got %0d expected %0d", fc, exp_fc);
        end
        n_checks++;
        if (uc !== exp_uc) begin
            n_fail++;
            $display("[TB] FAIL random_underrun_count: got %0d expected %0d", uc, exp_uc);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        test_reset();
        test_idle_stream();
        test_frame_x1();
        test_replication_x10();
        test_underrun();
        test_speed_change();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
